// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter
// Packet-level round-robin arbiter that shares one AXI-stream write port
// (FIFO data_i/valid_i/ready_i side) between NUM_SRC source masters. A grant
// is held from the first beat up to and including the tlast beat, so packets
// never interleave downstream. Beats pass through combinationally while a
// packet is in flight; one idle cycle separates consecutive packets.
//
// Ports:
//   aclk, areset              clock, synchronous active-high reset
//   s_axis_tvalid/tready      per-source handshake (NUM_SRC bits each)
//   s_axis_tdata              flattened data, source i at [i*TDATA_WIDTH +: TDATA_WIDTH]
//   s_axis_tkeep/tlast        per-source sideband (NUM_SRC bits each)
//   m_axis_*                  muxed stream towards the FIFO ({tkeep, tlast, tdata})
//   grant_o                   index of the current or most recently granted source
//   busy_o                    high while a packet is being passed through
//   pkt_cnt_clr_i, pkt_cnt_o  optional per-source packet counters (16 bits each),
//                             only present when ARB_PKT_CNT_EN is defined
module axis_packet_arbiter #(
    parameter  int unsigned NUM_SRC     = 4,
    parameter  int unsigned TDATA_WIDTH = 8,
    localparam int unsigned GRANT_W     = $clog2(NUM_SRC)
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [NUM_SRC-1:0]             s_axis_tvalid,
    output logic [NUM_SRC-1:0]             s_axis_tready,
    input  logic [NUM_SRC*TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]             s_axis_tkeep,
    input  logic [NUM_SRC-1:0]             s_axis_tlast,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
    output logic                           m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic [GRANT_W-1:0]             grant_o,
    output logic                           busy_o
`ifdef ARB_PKT_CNT_EN
    ,
    input  logic                           pkt_cnt_clr_i,
    output logic [NUM_SRC*16-1:0]          pkt_cnt_o
`endif
);

    typedef enum logic {IDLE, PASS} state_t;

    state_t                   state;
    logic [GRANT_W-1:0]       rr_ptr;
    logic [GRANT_W-1:0]       next_grant;
    logic                     req_any;
    logic                     last_hs;
    logic [TDATA_WIDTH-1:0]   src_data [NUM_SRC];

    // Unflatten source data so the mux can index by grant
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_data[i] = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
    end

    // Round-robin search: first valid source after rr_ptr, modulo NUM_SRC.
    // Iterating from the farthest offset down leaves the nearest one selected.
    always_comb begin : rr_search
        logic [GRANT_W-1:0] idx;
        idx        = '0;
        next_grant = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = GRANT_W'((32'(rr_ptr) + 32'(k)) % NUM_SRC);
            if (s_axis_tvalid[idx]) begin
                next_grant = idx;
            end
        end
    end

    assign req_any = |s_axis_tvalid;

    // Zero-latency pass-through of the granted source while in PASS
    always_comb begin : pass_mux
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = 1'b0;
        m_axis_tlast  = 1'b0;
        if (state == PASS) begin
            s_axis_tready[grant_o] = m_axis_tready;
            m_axis_tvalid          = s_axis_tvalid[grant_o];
            m_axis_tdata           = src_data[grant_o];
            m_axis_tkeep           = s_axis_tkeep[grant_o];
            m_axis_tlast           = s_axis_tlast[grant_o];
        end
    end

    // Final beat of the granted packet is accepted downstream
    assign last_hs = (state == PASS) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Arbitration FSM; rr_ptr starts at NUM_SRC-1 so source 0 wins first
    always_ff @(posedge aclk) begin : arb_fsm
        if (areset) begin
            state   <= IDLE;
            rr_ptr  <= GRANT_W'(NUM_SRC - 1);
            grant_o <= '0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant_o <= next_grant;
                        state   <= PASS;
                        busy_o  <= 1'b1;
                    end
                end
                PASS: begin
                    if (last_hs) begin
                        rr_ptr <= grant_o;
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_PKT_CNT_EN
    logic [15:0] pkt_cnt [NUM_SRC];

    // Per-source completed-packet counters; clear beats a same-cycle increment
    always_ff @(posedge aclk) begin : pkt_counters
        for (int i = 0; i < NUM_SRC; i++) begin
            if (areset || pkt_cnt_clr_i) begin
                pkt_cnt[i] <= '0;
            end else if (last_hs && (grant_o == GRANT_W'(i))) begin
                pkt_cnt[i] <= pkt_cnt[i] + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt_flat
        assign pkt_cnt_o[i*16 +: 16] = pkt_cnt[i];
    end
`endif

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Packet-level round-robin arbiter sharing one AXI_FIFO write port between NUM_SRC AXI-stream sources.
- Sits between the source masters and the FIFO's data_i/valid_i/ready_i side.
- Grant is held from the first beat to the tlast beat, so packets are never interleaved in the FIFO.
- Downstream format is {tkeep, tlast, tdata}, the same as the FIFO input.

Parameters:
- NUM_SRC, 4, number of requesting stream sources (2..8).
- TDATA_WIDTH, 8, data width per beat in bits.
- GRANT_W, $clog2(NUM_SRC), width of the grant index (derived, not overridden).

Ports:
- aclk  in  1  single clock; all logic on rising edge.
- areset  in  1  synchronous reset, active-high.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tready  out  NUM_SRC  per-source ready.
- s_axis_tdata  in  NUM_SRC*TDATA_WIDTH  flattened data; source i occupies bits [i*TDATA_WIDTH +: TDATA_WIDTH].
- s_axis_tkeep  in  NUM_SRC  per-source keep.
- s_axis_tlast  in  NUM_SRC  per-source last.
- m_axis_tvalid  out  1  to FIFO valid_i.
- m_axis_tready  in  1  from FIFO ready_i.
- m_axis_tdata  out  TDATA_WIDTH  muxed data.
- m_axis_tkeep  out  1  muxed keep.
- m_axis_tlast  out  1  muxed last.
- grant_o  out  GRANT_W  index of the current or last granted source.
- busy_o  out  1  high while in PASS.

Behaviour:
- Reset (areset=1 at a rising edge):
  - state=IDLE, rr_ptr=NUM_SRC-1, grant_o=0, busy_o=0.
  - s_axis_tready=0 on all sources, m_axis_tvalid=0.
  - All outputs take their reset values in the cycle after the reset edge.
- States: IDLE, PASS.
- IDLE:
  - No source is ready; m_axis_tvalid=0.
  - If any s_axis_tvalid bit is set, select the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC.
  - On the next edge register that index into grant_o and go to PASS.
  - If no valid bit is set, stay in IDLE.
- PASS (combinational pass-through, zero added latency per beat):
  - m_axis_{tvalid,tdata,tkeep,tlast} come from source grant_o.
  - s_axis_tready[grant_o]=m_axis_tready; every other s_axis_tready bit is 0.
  - busy_o=1.
- PASS exit:
  - On an edge where m_axis_tvalid & m_axis_tready & m_axis_tlast: rr_ptr<=grant_o, state<=IDLE.
  - This gives exactly one bubble cycle between packets.
- Request-to-first-beat latency is one cycle: a valid seen in IDLE at edge N allows transfer at edge N+1.
- The arbiter never drops or modifies a beat. tdata/tkeep/tlast pass through unaltered.
- Sources must hold valid and data until their ready (AXI-stream rules). The arbiter does not check this.
- Boundary conditions:
  - Single-beat packet (tlast on the first beat): PASS lasts one handshake cycle, then IDLE.
  - FIFO full (m_axis_tready=0): stay in PASS indefinitely. The granted source stalls; the others see ready=0.
  - Granted source drops valid mid-packet (idle gap): grant is held and no other source is served until its tlast.
  - Only one requester: it is re-granted after each one-cycle bubble.
  - All sources requesting continuously: strict rotation 0,1,2,3,0,... starting from source 0 after reset.
  - areset asserted mid-packet: return to IDLE immediately and drop all readies. The partial packet in the FIFO is not repaired; upstream reset is required to match.
  - rr_ptr wraps from NUM_SRC-1 to 0.

Optional Feature:
- Macro: ARB_PKT_CNT_EN.
- Defined:
  - Adds output pkt_cnt_o, NUM_SRC*16 bits; source i occupies bits [i*16 +: 16].
  - Counter i increments by 1 on each tlast handshake from source i, wraps 0xFFFF->0, and resets to 0 on areset.
  - Adds input pkt_cnt_clr_i, 1 bit: synchronously clears all counters. Clear wins over a same-cycle increment.
- Not defined: neither port exists and no counter logic is built; arbitration behaviour is identical.

Test Plan:
- Reset: hold areset 3 cycles with all sources valid -> all s_axis_tready=0, m_axis_tvalid=0, busy_o=0, grant_o=0 throughout; first grant after release is source 0.
- Fairness: sources 0..3 each offer continuous 3-beat packets with m_axis_tready=1 -> output packet order 0,1,2,3,0,1,2,3; each packet 3 contiguous beats; one idle cycle between packets.
- Backpressure: source 2 sends 5 beats (0xA0..0xA4), m_axis_tready low for 4 cycles after beat 2 -> output data exactly A0..A4 in order; source 1, valid throughout, is not granted until the cycle after the A4/tlast handshake.
- Single-beat packets: sources 1 and 3 alternate single-beat tlast=1 packets -> grant_o alternates 1,3,1,3; busy_o high exactly 1 cycle per packet.
- Mid-packet reset: areset asserted on beat 2 of 4 from source 0 -> next cycle state IDLE, all readies 0; after release, source 0 requesting is granted first.
- ARB_PKT_CNT_EN: 10 packets from source 1, then 2 from source 3 -> pkt_cnt_o[1]=10, [3]=2, others 0; pulse pkt_cnt_clr_i during a tlast handshake -> all counters 0.
